// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the 4-digit seven-segment scanner.
// All display signals are active-low.
package seven_seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF = 4'hF;
  localparam int NUM_DIGITS = 4;

  localparam logic [3:0] AN_DIG1 = 4'b1110;
  localparam logic [3:0] AN_DIG2 = 4'b1101;
  localparam logic [3:0] AN_DIG3 = 4'b1011;
  localparam logic [3:0] AN_DIG4 = 4'b0111;

  typedef enum logic [1:0] {
    PH_BLANK,
    PH_ON,
    PH_DIM
  } phase_e;

  // Index 0 is digit1 (rightmost).
  function automatic logic [3:0] an_sel(
    input logic [1:0] digit
  );
    logic [3:0] an;
    unique case (digit)
      2'd0: an = AN_DIG1;
      2'd1: an = AN_DIG2;
      2'd2: an = AN_DIG3;
      default: an = AN_DIG4;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/seven_seg_frame_buffer.sv
// Double-buffered frame store: a pending slot fed by a valid/ready
// handshake and an active copy that only changes on a scan boundary.
module seven_seg_frame_buffer
  import seven_seg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        boundary,
  input  logic [31:0] frame_in,
  input  logic        valid,
  output logic [31:0] active,
  output logic        ready
);

  logic [31:0] pending;
  logic        full;
  logic        accept;

  assign ready  = !full;
  assign accept = valid && ready;

  // Boundary drains pending (or bypasses an empty one); otherwise fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= '1;
      pending <= '1;
      full    <= 1'b0;
    end else if (boundary) begin
      if (full) begin
        active <= pending;
        full   <= 1'b0;
      end else if (accept) begin
        active <= frame_in;
      end
    end else if (accept) begin
      pending <= frame_in;
      full    <= 1'b1;
    end
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed 4-digit common-anode driver with
// per-slot blanking and PWM dimming.
module seven_segment_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] frame_in,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [2:0]  brightness,
  input  logic        enable,
  output logic [7:0]  seg_out,
  output logic [3:0]  an_out,
  output logic        frame_done
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam int SPAN = DIGIT_CYCLES - BLANK_CYCLES;
  localparam logic [CW-1:0] LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [1:0] DIG_LAST = 2'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [1:0]    digit;
  logic [1:0]    digit_n;
  logic [2:0]    bright_q;
  logic [2:0]    bright_sel;
  phase_e        ph;
  phase_e        ph_n;
  logic          last;
  logic          scan_end;
  logic          boundary;
  logic [31:0]   active;
  int            thr;

  assign last     = cnt == LAST;
  assign scan_end = last && digit == DIG_LAST;
  assign boundary = !enable || scan_end;

  seven_seg_frame_buffer u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .boundary (boundary),
    .frame_in (frame_in),
    .valid    (frame_valid),
    .active   (active),
    .ready    (frame_ready)
  );

  // Next counter values and the phase the next cycle falls in.
  // At cnt==0 the live brightness is the one being sampled.
  always_comb begin
    cnt_n      = cnt + 1'b1;
    digit_n    = digit;
    bright_sel = (cnt == '0) ? brightness : bright_q;
    thr        = BLANK_CYCLES
               + (((int'(bright_sel) + 1) * SPAN) >> 3);
    ph_n       = PH_DIM;
    if (!enable) begin
      cnt_n   = '0;
      digit_n = 2'd0;
    end else if (last) begin
      cnt_n   = '0;
      digit_n = digit + 1'b1;
    end
    if (!enable || int'(cnt_n) < BLANK_CYCLES) begin
      ph_n = PH_BLANK;
    end else if (int'(cnt_n) < thr) begin
      ph_n = PH_ON;
    end
  end

  // Slot counter, digit index, phase and per-slot brightness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      digit    <= 2'd0;
      ph       <= PH_BLANK;
      bright_q <= 3'd7;
    end else begin
      cnt   <= cnt_n;
      digit <= digit_n;
      ph    <= ph_n;
      if (cnt == '0) begin
        bright_q <= brightness;
      end
    end
  end

  // Registered display outputs; anode and segments move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out    <= SEG_BLANK;
      an_out     <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      if (enable && ph == PH_ON) begin
        seg_out <= active[{digit, 3'b000} +: 8];
        an_out  <= an_sel(digit);
      end else begin
        seg_out <= SEG_BLANK;
        an_out  <= AN_OFF;
      end
      frame_done <= enable && scan_end;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: per-scenario tasks with a
// scoreboard of expected per-cycle segment/anode values.
module tb_seven_segment_scanner;

  localparam int DC = 16;
  localparam int BC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] frame_in;
  logic        frame_valid;
  logic        frame_ready;
  logic [2:0]  brightness;
  logic        enable;
  logic [7:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_done;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] an;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  localparam logic [31:0] F1 = 32'hFFF9_C0C0;
  localparam logic [31:0] FA = 32'h8182_8384;
  localparam logic [31:0] FB = 32'h0F1E_2D3C;
  localparam logic [31:0] FC = 32'hC6C7_C8C9;
  localparam logic [31:0] FD = 32'h6D7D_077F;
  localparam logic [31:0] FE = 32'h1234_5678;

  seven_segment_scanner #(
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .brightness  (brightness),
    .enable      (enable),
    .seg_out     (seg_out),
    .an_out      (an_out),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  function automatic int thr(input int b);
    return BC + (((b + 1) * (DC - BC)) >> 3);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!frame_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (frame_done !== 1'b1) begin
      bad++;
      $display("FAIL %s done_wait: frame_done=%b want 1", tag, frame_done);
    end
  endtask

  task automatic send(input logic [31:0] f, input string tag);
    int n = 0;
    frame_in    = f;
    frame_valid = 1'b1;
    while (!frame_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (frame_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s send: ready=%b want 1", tag, frame_ready);
    end
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  // Starts at a negedge where the DUT counter sits at digit1 cnt 0.
  task automatic run_scan(
    input logic [31:0] f,
    input int          t1,
    input int          t2,
    input int          chg,
    input logic [2:0]  cv,
    input string       tag
  );
    exp_t e;
    int   d;
    int   c;
    int   t;
    logic lit;
    for (int i = 0; i < 4 * DC; i++) begin
      d   = i / DC;
      c   = i % DC;
      t   = (d == 0) ? t1 : t2;
      lit = (c >= BC) && (c < t);
      e.seg = lit ? f[d*8 +: 8] : 8'hFF;
      e.an  = lit ? ~(4'b0001 << d) : 4'hF;
      sb.push_back(e);
    end
    for (int i = 0; i < 4 * DC; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 0) frame_valid = 1'b0;
      e = sb.pop_front();
      total++;
      if (seg_out !== e.seg || an_out !== e.an) begin
        bad++;
        $display("FAIL %s[%0d] d%0d c%0d: seg=%h an=%b want seg=%h an=%b",
                 tag, i, i / DC + 1, i % DC, seg_out, an_out, e.seg, e.an);
      end
      if (i == chg) brightness = cv;
    end
  endtask

  task automatic test_reset;
    rst_n       = 1'b0;
    frame_in    = '0;
    frame_valid = 1'b0;
    brightness  = 3'd7;
    enable      = 1'b1;
    tick(2);
    total++;
    if (seg_out !== 8'hFF || an_out !== 4'hF) begin
      bad++;
      $display("FAIL reset_out: seg=%h an=%b want FF 1111", seg_out, an_out);
    end
    total++;
    if (frame_ready !== 1'b1 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs: ready=%b done=%b want 1 0",
               frame_ready, frame_done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_frame_load;
    send(F1, "load");
    wait_done("load");
    run_scan(F1, thr(7), thr(7), -1, 3'd0, "load");
  endtask

  task automatic test_dimming;
    brightness = 3'd3;
    run_scan(F1, thr(3), thr(3), -1, 3'd0, "dim");
    run_scan(F1, thr(3), thr(7), 5, 3'd7, "dim_mid");
  endtask

  task automatic test_back_to_back;
    send(FA, "bp_a");
    frame_in    = FB;
    frame_valid = 1'b1;
    total++;
    if (frame_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_hold: ready=%b want 0", frame_ready);
    end
    wait_done("bp");
    total++;
    if (frame_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_rise: ready=%b want 1", frame_ready);
    end
    run_scan(FA, thr(7), thr(7), -1, 3'd0, "bp_a");
    run_scan(FB, thr(7), thr(7), -1, 3'd0, "bp_b");
  endtask

  task automatic test_bypass;
    tick(4 * DC - 1);
    frame_in    = FC;
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    total++;
    if (frame_done !== 1'b1 || frame_ready !== 1'b1) begin
      bad++;
      $display("FAIL bypass_edge: done=%b ready=%b want 1 1",
               frame_done, frame_ready);
    end
    run_scan(FC, thr(7), thr(7), -1, 3'd0, "bypass");
  endtask

  task automatic test_enable_drop;
    tick(DC + 7);
    total++;
    if (seg_out !== 8'hC8 || an_out !== 4'b1101) begin
      bad++;
      $display("FAIL en_lit: seg=%h an=%b want C8 1101", seg_out, an_out);
    end
    enable = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      total++;
      if (seg_out !== 8'hFF || an_out !== 4'hF || frame_done !== 1'b0) begin
        bad++;
        $display("FAIL en_off[%0d]: seg=%h an=%b done=%b want FF 1111 0",
                 i, seg_out, an_out, frame_done);
      end
      if (i == 10) begin
        send(FD, "en_send");
        total++;
        if (frame_ready !== 1'b1) begin
          bad++;
          $display("FAIL en_bypass: ready=%b want 1", frame_ready);
        end
      end
    end
    enable = 1'b1;
    run_scan(FD, thr(7), thr(7), -1, 3'd0, "reenable");
  endtask

  task automatic test_reset_mid;
    send(FE, "rst_fill");
    tick(2 * DC + 6 - 1);
    total++;
    if (seg_out !== 8'h7D || an_out !== 4'b1011 || frame_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_pre: seg=%h an=%b ready=%b want 7D 1011 0",
               seg_out, an_out, frame_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (seg_out !== 8'hFF || an_out !== 4'hF) begin
      bad++;
      $display("FAIL rst_async_out: seg=%h an=%b want FF 1111",
               seg_out, an_out);
    end
    total++;
    if (frame_ready !== 1'b1 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL rst_async_hs: ready=%b done=%b want 1 0",
               frame_ready, frame_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_scan(32'hFFFF_FFFF, thr(7), thr(7), -1, 3'd0, "rst_scan1");
    run_scan(32'hFFFF_FFFF, thr(7), thr(7), -1, 3'd0, "rst_scan2");
  endtask

  initial begin
    test_reset();
    test_frame_load();
    test_dimming();
    test_back_to_back();
    test_bypass();
    test_enable_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
